// File: rtl/arbiter_mux.sv
// N-channel arbiter feeding a single registered output stage.
// Fixed-priority or round-robin grant, with one beat per cycle while downstream accepts.
module arbiter_mux #(
   parameter int P_WIDTH = 2,
   parameter int P_DEPTH = 16,
   parameter int P_MODE  = 0
) (
   input  logic                            I_CLK,
   input  logic                            I_RESET,
   input  logic [P_WIDTH-1:0][P_DEPTH-1:0] I_INPUT,
   input  logic [P_WIDTH-1:0]              I_VALID,
   output logic [P_WIDTH-1:0]              O_READY,
   output logic [P_DEPTH-1:0]              O_OUTPUT,
   output logic                            O_VALID,
   input  logic                            I_READY,
   output logic [$clog2(P_WIDTH)-1:0]      O_SELECT
);

   localparam int SEL_W = $clog2(P_WIDTH);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(P_WIDTH - 1);
   localparam logic [SEL_W:0]   WIDTH_EXT = (SEL_W + 1)'(P_WIDTH);

   logic [P_DEPTH-1:0] data_reg;
   logic [SEL_W-1:0]   sel_reg;
   logic               valid_reg;
   logic [SEL_W-1:0]   ptr_reg;

   logic [SEL_W-1:0]              search_base;
   logic [P_WIDTH-1:0][SEL_W-1:0] cand_idx;
   logic [P_WIDTH-1:0]            cand_valid;
   logic [SEL_W-1:0]              grant_idx;
   logic                          grant_found;
   logic                          load_en;

   assign load_en     = ~valid_reg | I_READY;
   assign search_base = (P_MODE == 1) ? ptr_reg : '0;

   // Slot gi of the search order holds channel (base + gi) mod P_WIDTH.
   for (genvar gi = 0; gi < P_WIDTH; gi++) begin : g_slot
      logic [SEL_W:0] sum;
      assign sum             = {1'b0, search_base} + (SEL_W + 1)'(gi);
      assign cand_idx[gi]    = (sum >= WIDTH_EXT) ? SEL_W'(sum - WIDTH_EXT) : sum[SEL_W-1:0];
      assign cand_valid[gi]  = I_VALID[cand_idx[gi]];
      assign O_READY[gi]     = ~I_RESET & load_en & grant_found & (grant_idx == SEL_W'(gi));
   end

   // Walk the slots from the back so the earliest valid slot wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = P_WIDTH - 1; i >= 0; i--) begin
         if (cand_valid[i]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx[i];
         end
      end
   end

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         data_reg  <= '0;
         sel_reg   <= '0;
         valid_reg <= 1'b0;
         ptr_reg   <= '0;
      end else if (load_en) begin
         valid_reg <= grant_found;
         if (grant_found) begin
            data_reg <= I_INPUT[grant_idx];
            sel_reg  <= grant_idx;
            ptr_reg  <= (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_W'(1);
         end
      end
   end

   assign O_OUTPUT = data_reg;
   assign O_SELECT = sel_reg;
   assign O_VALID  = valid_reg;

endmodule

// File: tb/tb_arbiter_mux.sv
// Vector table plus scoreboard for three arbiter_mux configurations sharing one stimulus:
// 4-channel fixed priority, 4-channel round-robin, 3-channel round-robin.
module tb_arbiter_mux;

   logic             clk;
   logic             rst;
   logic [3:0][15:0] din;
   logic [3:0]       vld;
   logic             rdy;

   logic [3:0]  fp_ready, rr_ready;
   logic [2:0]  r3_ready;
   logic [15:0] fp_out, rr_out, r3_out;
   logic        fp_valid, rr_valid, r3_valid;
   logic [1:0]  fp_sel, rr_sel, r3_sel;

   arbiter_mux #(.P_WIDTH(4), .P_DEPTH(16), .P_MODE(0)) u_fp4 (
      .I_CLK(clk), .I_RESET(rst), .I_INPUT(din), .I_VALID(vld), .O_READY(fp_ready),
      .O_OUTPUT(fp_out), .O_VALID(fp_valid), .I_READY(rdy), .O_SELECT(fp_sel));

   arbiter_mux #(.P_WIDTH(4), .P_DEPTH(16), .P_MODE(1)) u_rr4 (
      .I_CLK(clk), .I_RESET(rst), .I_INPUT(din), .I_VALID(vld), .O_READY(rr_ready),
      .O_OUTPUT(rr_out), .O_VALID(rr_valid), .I_READY(rdy), .O_SELECT(rr_sel));

   arbiter_mux #(.P_WIDTH(3), .P_DEPTH(16), .P_MODE(1)) u_rr3 (
      .I_CLK(clk), .I_RESET(rst), .I_INPUT(din[2:0]), .I_VALID(vld[2:0]), .O_READY(r3_ready),
      .O_OUTPUT(r3_out), .O_VALID(r3_valid), .I_READY(rdy), .O_SELECT(r3_sel));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       pre_rst;
      logic [3:0] vld;
      logic       rdy;
      logic       ov;
      logic [3:0] r_fp;
      logic [3:0] r_rr;
      logic [2:0] r_r3;
      logic [1:0] s_fp;
      logic [1:0] s_rr;
      logic [1:0] s_r3;
   } vec_t;

   typedef struct {
      int          dut;
      int          idx;
      logic        ov;
      logic [1:0]  sel;
      logic [15:0] data;
   } exp_t;

   localparam int NVEC = 26;
   vec_t        tbl[NVEC];
   exp_t        sb_q[$];
   logic [15:0] exp_data[3];
   string       names[3] = '{"fp4", "rr4", "rr3"};
   int          checks   = 0;
   int          failures = 0;

   function automatic vec_t mk(input logic pre, input logic [3:0] v, input logic rd, input logic ov,
                               input logic [3:0] rfp, input logic [3:0] rrr, input logic [2:0] rr3,
                               input logic [1:0] sfp, input logic [1:0] srr, input logic [1:0] sr3);
      vec_t t;
      t.pre_rst = pre; t.vld = v; t.rdy = rd; t.ov = ov;
      t.r_fp = rfp; t.r_rr = rrr; t.r_r3 = rr3;
      t.s_fp = sfp; t.s_rr = srr; t.s_r3 = sr3;
      return t;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, req);
      end
   endtask

   // Reset is raised and checked between clock edges, with requests active.
   task automatic do_reset(input int idx);
      vld = 4'b1111;
      rdy = 1'b1;
      rst = 1'b1;
      #1;
      chk("rst_fp4_valid", idx, 32'(fp_valid), 32'd0);
      chk("rst_fp4_out",   idx, 32'(fp_out),   32'd0);
      chk("rst_fp4_sel",   idx, 32'(fp_sel),   32'd0);
      chk("rst_fp4_ready", idx, 32'(fp_ready), 32'd0);
      chk("rst_rr4_valid", idx, 32'(rr_valid), 32'd0);
      chk("rst_rr4_out",   idx, 32'(rr_out),   32'd0);
      chk("rst_rr4_sel",   idx, 32'(rr_sel),   32'd0);
      chk("rst_rr4_ready", idx, 32'(rr_ready), 32'd0);
      chk("rst_rr3_valid", idx, 32'(r3_valid), 32'd0);
      chk("rst_rr3_out",   idx, 32'(r3_out),   32'd0);
      chk("rst_rr3_sel",   idx, 32'(r3_sel),   32'd0);
      chk("rst_rr3_ready", idx, 32'(r3_ready), 32'd0);
      #1 rst = 1'b0;
      for (int d = 0; d < 3; d++) exp_data[d] = 16'h0000;
   endtask

   initial begin
      exp_t        e;
      logic        a_v;
      logic [1:0]  a_s;
      logic [15:0] a_d;

      // fixed priority starves channel 3; round-robin alternates
      tbl[0]  = mk(1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 4'b0010, 3'b010, 2'd1, 2'd1, 2'd1);
      tbl[1]  = mk(1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 4'b1000, 3'b010, 2'd1, 2'd3, 2'd1);
      tbl[2]  = mk(1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 4'b0010, 3'b010, 2'd1, 2'd1, 2'd1);
      tbl[3]  = mk(1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 4'b1000, 3'b010, 2'd1, 2'd3, 2'd1);
      // all valid from reset
      tbl[4]  = mk(1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 4'b0001, 3'b001, 2'd0, 2'd0, 2'd0);
      tbl[5]  = mk(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 4'b0010, 3'b010, 2'd0, 2'd1, 2'd1);
      tbl[6]  = mk(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 4'b0100, 3'b100, 2'd0, 2'd2, 2'd2);
      tbl[7]  = mk(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 4'b1000, 3'b001, 2'd0, 2'd3, 2'd0);
      tbl[8]  = mk(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 4'b0001, 3'b010, 2'd0, 2'd0, 2'd1);
      // channels 0 and 2 only: rr3 must wrap from 2 back to 0
      tbl[9]  = mk(1'b1, 4'b0101, 1'b1, 1'b1, 4'b0001, 4'b0001, 3'b001, 2'd0, 2'd0, 2'd0);
      tbl[10] = mk(1'b0, 4'b0101, 1'b1, 1'b1, 4'b0001, 4'b0100, 3'b100, 2'd0, 2'd2, 2'd2);
      tbl[11] = mk(1'b0, 4'b0101, 1'b1, 1'b1, 4'b0001, 4'b0001, 3'b001, 2'd0, 2'd0, 2'd0);
      tbl[12] = mk(1'b0, 4'b0101, 1'b1, 1'b1, 4'b0001, 4'b0100, 3'b100, 2'd0, 2'd2, 2'd2);
      // five-cycle stall with changing data, then load on release
      for (int i = 13; i <= 17; i++)
         tbl[i] = mk(1'b0, 4'b1111, 1'b0, 1'b1, 4'b0000, 4'b0000, 3'b000, 2'd0, 2'd2, 2'd2);
      tbl[18] = mk(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 4'b1000, 3'b001, 2'd0, 2'd3, 2'd0);
      // drain, idle, load into empty register without downstream ready, then hold
      tbl[19] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 3'b000, 2'd0, 2'd3, 2'd0);
      tbl[20] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'b000, 2'd0, 2'd3, 2'd0);
      tbl[21] = mk(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0100, 3'b100, 2'd2, 2'd2, 2'd2);
      tbl[22] = mk(1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, 4'b0000, 3'b000, 2'd2, 2'd2, 2'd2);
      // reset while holding select 2; pointer restarts at 0
      tbl[23] = mk(1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 4'b0001, 3'b001, 2'd0, 2'd0, 2'd0);
      tbl[24] = mk(1'b0, 4'b1100, 1'b1, 1'b1, 4'b0100, 4'b0100, 3'b100, 2'd2, 2'd2, 2'd2);
      tbl[25] = mk(1'b0, 4'b1100, 1'b1, 1'b1, 4'b0100, 4'b1000, 3'b100, 2'd2, 2'd3, 2'd2);

      rst = 1'b1;
      vld = 4'b0000;
      rdy = 1'b0;
      din = '0;
      @(posedge clk);
      #1;
      do_reset(-1);

      for (int i = 0; i < NVEC; i++) begin
         if (tbl[i].pre_rst) do_reset(i);
         vld = tbl[i].vld;
         rdy = tbl[i].rdy;
         for (int c = 0; c < 4; c++) din[c] = {12'(i), 4'(c)};

         if (tbl[i].r_fp != 4'b0000) exp_data[0] = {12'(i), 2'b00, tbl[i].s_fp};
         if (tbl[i].r_rr != 4'b0000) exp_data[1] = {12'(i), 2'b00, tbl[i].s_rr};
         if (tbl[i].r_r3 != 3'b000)  exp_data[2] = {12'(i), 2'b00, tbl[i].s_r3};
         sb_q.push_back('{dut: 0, idx: i, ov: tbl[i].ov, sel: tbl[i].s_fp, data: exp_data[0]});
         sb_q.push_back('{dut: 1, idx: i, ov: tbl[i].ov, sel: tbl[i].s_rr, data: exp_data[1]});
         sb_q.push_back('{dut: 2, idx: i, ov: tbl[i].ov, sel: tbl[i].s_r3, data: exp_data[2]});

         @(negedge clk);
         chk("fp4_ready", i, 32'(fp_ready), 32'(tbl[i].r_fp));
         chk("rr4_ready", i, 32'(rr_ready), 32'(tbl[i].r_rr));
         chk("rr3_ready", i, 32'(r3_ready), 32'(tbl[i].r_r3));

         @(posedge clk);
         #1;
         repeat (3) begin
            e = sb_q.pop_front();
            case (e.dut)
               0:       begin a_v = fp_valid; a_s = fp_sel; a_d = fp_out; end
               1:       begin a_v = rr_valid; a_s = rr_sel; a_d = rr_out; end
               default: begin a_v = r3_valid; a_s = r3_sel; a_d = r3_out; end
            endcase
            chk({names[e.dut], "_valid"}, e.idx, 32'(a_v), 32'(e.ov));
            chk({names[e.dut], "_sel"},   e.idx, 32'(a_s), 32'(e.sel));
            chk({names[e.dut], "_out"},   e.idx, 32'(a_d), 32'(e.data));
         end
         $display("vec %0d valid=%b ready=%b -> sel fp4/rr4/rr3=%0d/%0d/%0d ovalid=%b%b%b",
                  i, vld, rdy, fp_sel, rr_sel, r3_sel, fp_valid, rr_valid, r3_valid);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arbiter_mux.md
ARBITER_MUX -- requirements
Module: arbiter_mux

Interface
REQ-001 SHALL have parameter P_WIDTH, default 2, number of input channels (>=2; non-power-of-2 allowed).
REQ-002 SHALL have parameter P_DEPTH, default 16, data bits per channel.
REQ-003 SHALL have parameter P_MODE, default 0, arbitration mode (0 = fixed priority, 1 = round-robin).
REQ-004 SHALL have port I_CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port I_RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port I_INPUT  input  [P_WIDTH][P_DEPTH]  per-channel data, packed 2-D, channel index in the first dimension.
REQ-007 SHALL have port I_VALID  input  P_WIDTH  per-channel data-valid.
REQ-008 SHALL have port O_READY  output  P_WIDTH  per-channel accept; at most one bit high per cycle.
REQ-009 SHALL have port O_OUTPUT  output  P_DEPTH  registered selected data.
REQ-010 SHALL have port O_VALID  output  1  O_OUTPUT holds an unconsumed beat.
REQ-011 SHALL have port I_READY  input  1  downstream accept.
REQ-012 SHALL have port O_SELECT  output  $clog2(P_WIDTH)  channel index of the beat in O_OUTPUT.

Function
REQ-013 SHALL contain one output register stage (data, select, valid); latency from input transfer to O_VALID = 1 cycle.
REQ-014 SHALL define load_en = ~O_VALID | I_READY (register empty or draining this cycle).
REQ-015 SHALL drive O_READY[g] = 1 combinationally only when load_en = 1, I_VALID[g] = 1 and g is the granted channel; all other bits 0.
REQ-016 SHALL treat a transfer on channel g as I_VALID[g] & O_READY[g]; on transfer, register I_INPUT[g] into O_OUTPUT, g into O_SELECT, set O_VALID.
REQ-017 SHALL, when load_en = 1, I_READY = 1 and no I_VALID asserted, clear O_VALID next cycle; O_OUTPUT and O_SELECT retain last values.
REQ-018 SHALL hold O_OUTPUT, O_SELECT, O_VALID stable while O_VALID = 1 and I_READY = 0; O_READY all 0 in that state.
REQ-019 SHALL sustain one transfer per cycle when I_READY held 1 and any I_VALID asserted.
REQ-020 SHALL, in P_MODE 0, grant the lowest-index channel with I_VALID = 1.
REQ-021 SHALL, in P_MODE 1, keep a pointer ptr; search order ptr, ptr+1, ..., wrapping modulo P_WIDTH; grant first valid channel found.
REQ-022 SHALL update ptr only on a transfer, to (g+1) mod P_WIDTH; for non-power-of-2 P_WIDTH, ptr never takes values >= P_WIDTH.
REQ-023 SHALL not alter ptr when no transfer occurs (stall or no valid).
REQ-024 SHALL ignore I_INPUT of non-granted channels; I_VALID deassertion without transfer is permitted and causes no state change.
REQ-025 SHALL contain no combinational path from I_INPUT to O_OUTPUT; I_READY -> O_READY and I_VALID -> O_READY paths are allowed.

Reset
REQ-026 SHALL, while I_RESET = 1 (asynchronously, independent of I_CLK), force O_VALID = 0, O_OUTPUT = 0, O_SELECT = 0, ptr = 0.
REQ-027 SHALL drive O_READY all 0 while I_RESET = 1.
REQ-028 SHALL discard any beat held in the register when reset asserts mid-operation; first grant after reset release follows reset priority (channel 0 highest).

Verification
REQ-029 SHALL cover: P_WIDTH=4, P_MODE=0, I_VALID=4'b1010, I_READY=1 held -> channel 1 granted every cycle, O_SELECT=1, channel 3 starved.
REQ-030 SHALL cover: P_WIDTH=4, P_MODE=1, I_VALID=4'b1111, I_READY=1 from reset -> O_SELECT sequence 0,1,2,3,0; one beat per cycle.
REQ-031 SHALL cover: P_WIDTH=3, P_MODE=1, I_VALID=3'b101 -> grants 0,2,0,2; ptr never reaches 3.
REQ-032 SHALL cover: O_VALID=1 with I_READY=0 for 5 cycles, I_INPUT changing -> O_OUTPUT/O_SELECT unchanged, O_READY=0; on I_READY=1 next beat loads same edge.
REQ-033 SHALL cover: I_RESET pulsed between clock edges while O_VALID=1, O_SELECT=2 -> O_VALID=0, O_OUTPUT=0, O_SELECT=0 immediately; next grant channel 0 if valid.
REQ-034 SHALL cover: all I_VALID=0, I_READY=1 after a beat -> O_VALID falls next cycle, O_OUTPUT retains last value.
